// File: rtl/tsmac_rx_fifo_reader.sv
// Read-side consumer of the TSMAC RX FIFO: pops {eop, err, byte} words, delineates frames,
// truncates oversize frames and drives a valid/ready byte stream with frame statistics.
module tsmac_rx_fifo_reader #(
    parameter int c_DATA_WIDTH = 8,
    parameter int c_MAX_LEN    = 1536,
    parameter int c_LEN_WIDTH  = 16,
    parameter int c_CNT_WIDTH  = 32
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst_n,
    input  logic [c_DATA_WIDTH+1:0] fifo_rd_data,
    input  logic                    fifo_rd_empty,
    output logic                    fifo_rd_en,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [c_DATA_WIDTH-1:0] m_data,
    output logic                    m_sop,
    output logic                    m_eop,
    output logic                    m_err,
    output logic [c_LEN_WIDTH-1:0]  m_len,
    output logic [c_CNT_WIDTH-1:0]  frame_cnt,
    output logic [c_CNT_WIDTH-1:0]  err_cnt,
    output logic [c_CNT_WIDTH-1:0]  trunc_cnt
);

    typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;

    // Buffer entry layout: {data, len, sop, eop, err, trunc}
    localparam int c_ENTRY_W = c_DATA_WIDTH + c_LEN_WIDTH + 4;
    localparam logic [c_LEN_WIDTH-1:0] c_MAX = c_LEN_WIDTH'(c_MAX_LEN);
    localparam logic [c_LEN_WIDTH-1:0] c_ONE = c_LEN_WIDTH'(1);

    state_t                   state_reg, state_next;
    logic [c_LEN_WIDTH-1:0]   len_reg, len_next, len_inc;
    logic                     rd_pend_reg;
    logic [1:0]               buf_cnt_reg;
    logic                     wr_ptr_reg, rd_ptr_reg;
    logic [c_CNT_WIDTH-1:0]   frame_cnt_reg, err_cnt_reg, trunc_cnt_reg;

    logic                     word_eop, word_err;
    logic [c_DATA_WIDTH-1:0]  word_byte;
    logic                     wr_en, wr_sop, wr_eop, wr_err, wr_trunc;
    logic [c_LEN_WIDTH-1:0]   wr_len;
    logic [c_ENTRY_W-1:0]     wr_entry, head;
    logic [c_ENTRY_W-1:0]     entries [2];
    logic                     fire;
    logic [2:0]               occ;

    assign word_eop  = fifo_rd_data[c_DATA_WIDTH+1];
    assign word_err  = fifo_rd_data[c_DATA_WIDTH];
    assign word_byte = fifo_rd_data[c_DATA_WIDTH-1:0];
    assign len_inc   = len_reg + c_ONE;

    assign m_valid = (buf_cnt_reg != 2'd0);
    assign fire    = m_valid & m_ready;

    // Words in flight plus buffered beats never exceed the two buffer slots.
    assign occ        = {1'b0, buf_cnt_reg} + {2'b00, rd_pend_reg} - {2'b00, fire};
    assign fifo_rd_en = rd_rst_n & ~fifo_rd_empty & (occ < 3'd2);

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        wr_en      = 1'b0;
        wr_sop     = 1'b0;
        wr_eop     = 1'b0;
        wr_err     = 1'b0;
        wr_trunc   = 1'b0;
        wr_len     = len_inc;
        if (rd_pend_reg) begin
            case (state_reg)
                IDLE: begin
                    wr_en    = 1'b1;
                    wr_sop   = 1'b1;
                    wr_len   = c_ONE;
                    len_next = c_ONE;
                    if (word_eop) begin
                        wr_eop = 1'b1;
                        wr_err = word_err;
                    end else begin
                        state_next = FRAME;
                    end
                end
                FRAME: begin
                    wr_en    = 1'b1;
                    len_next = len_inc;
                    if (word_eop) begin
                        wr_eop     = 1'b1;
                        wr_err     = word_err;
                        state_next = IDLE;
                    end else if (len_inc == c_MAX) begin
                        // Close the frame as errored and swallow the rest up to its eop
                        wr_eop     = 1'b1;
                        wr_err     = 1'b1;
                        wr_trunc   = 1'b1;
                        state_next = DROP;
                    end
                end
                DROP: begin
                    if (word_eop) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign wr_entry = {word_byte, wr_len, wr_sop, wr_eop, wr_err, wr_trunc};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [c_ENTRY_W-1:0] entry_reg;
            always_ff @(posedge rd_clk) begin
                if (wr_en && (wr_ptr_reg == 1'(gi))) entry_reg <= wr_entry;
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign head   = entries[rd_ptr_reg];
    // Gate with m_valid so stale slots never leak onto the outputs.
    assign m_data = m_valid ? head[c_ENTRY_W-1 -: c_DATA_WIDTH] : '0;
    assign m_len  = m_valid ? head[c_LEN_WIDTH+3:4] : '0;
    assign m_sop  = m_valid & head[3];
    assign m_eop  = m_valid & head[2];
    assign m_err  = m_valid & head[1];

    assign frame_cnt = frame_cnt_reg;
    assign err_cnt   = err_cnt_reg;
    assign trunc_cnt = trunc_cnt_reg;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            rd_pend_reg   <= 1'b0;
            buf_cnt_reg   <= 2'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
            trunc_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            rd_pend_reg <= fifo_rd_en;
            if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
            if (fire)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({wr_en, fire})
                2'b10:   buf_cnt_reg <= buf_cnt_reg + 2'd1;
                2'b01:   buf_cnt_reg <= buf_cnt_reg - 2'd1;
                default: buf_cnt_reg <= buf_cnt_reg;
            endcase
            if (fire && head[2]) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
                if (head[1]) err_cnt_reg   <= err_cnt_reg + 1'b1;
                if (head[0]) trunc_cnt_reg <= trunc_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tsmac_rx_fifo_reader.sv
// Directed bench for tsmac_rx_fifo_reader: a FIFO model feeds frames, a monitor captures
// accepted beats, and one task per scenario compares them against hand-computed values.
module tb_tsmac_rx_fifo_reader;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n = 1'b0;
    logic [9:0]  fifo_rd_data = '0;
    logic        fifo_rd_empty;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_sop, m_eop, m_err;
    logic [15:0] m_len;
    logic [31:0] frame_cnt, err_cnt, trunc_cnt;

    tsmac_rx_fifo_reader dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sop(m_sop), .m_eop(m_eop), .m_err(m_err), .m_len(m_len),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .trunc_cnt(trunc_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge rd_clk) cyc <= cyc + 1;

    // FIFO model: data appears one cycle after fifo_rd_en
    logic [9:0] mem [0:8191];
    int  wr_idx = 0;
    int  rd_idx = 0;
    logic gap = 1'b0;
    assign fifo_rd_empty = (rd_idx == wr_idx) || gap;
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_idx[12:0]];
            rd_idx <= rd_idx + 1;
        end
    end

    logic ready_base = 1'b1;
    logic tog = 1'b0;
    logic toggle_en = 1'b0;
    assign m_ready = toggle_en ? tog : ready_base;
    always @(posedge rd_clk) tog <= ~tog;

    // Monitor: capture accepted beats, watch stability, read issue and occupancy
    logic [7:0]  cap_data [0:8191];
    logic        cap_sop [0:8191];
    logic        cap_eop [0:8191];
    logic        cap_err [0:8191];
    logic [15:0] cap_len [0:8191];
    int          cap_cyc [0:8191];
    int cap_n = 0, issued_n = 0, accepted_n = 0, occ_base = 0;
    int occ_bad = 0, stab_bad = 0, empty_bad = 0;
    bit chk_occ = 1'b0;
    logic hold_v = 1'b0;
    logic [27:0] hold_bus = '0;
    always @(negedge rd_clk) begin
        if (fifo_rd_en && fifo_rd_empty) empty_bad++;
        if (chk_occ && fifo_rd_en &&
            (issued_n - accepted_n - occ_base - int'(m_valid && m_ready) >= 2)) occ_bad++;
        if (hold_v && ({m_valid, m_data, m_sop, m_eop, m_err, m_len} !== hold_bus)) stab_bad++;
        hold_v   = m_valid && !m_ready && rd_rst_n;
        hold_bus = {m_valid, m_data, m_sop, m_eop, m_err, m_len};
        if (fifo_rd_en) issued_n++;
        if (m_valid && m_ready && rd_rst_n) begin
            cap_data[cap_n] = m_data;
            cap_sop[cap_n]  = m_sop;
            cap_eop[cap_n]  = m_eop;
            cap_err[cap_n]  = m_err;
            cap_len[cap_n]  = m_len;
            cap_cyc[cap_n]  = cyc;
            cap_n++;
            accepted_n++;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_frame(input int n, input logic [7:0] base, input logic err, input logic last_eop);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            logic       last;
            b    = base + 8'(i);
            last = (i == n - 1);
            mem[wr_idx[12:0]] = {last & last_eop, last & err, b};
            wr_idx++;
        end
    endtask

    task automatic wait_beats(input int n, output bit ok);
        int k;
        k = 0;
        while (cap_n < n && k < 5000) begin
            tick();
            k++;
        end
        ok = (cap_n >= n);
    endtask

    task automatic test_reset();
        rd_rst_n   = 1'b0;
        ready_base = 1'b1;
        push_frame(1, 8'h5A, 1'b0, 1'b1);
        tick();
        tick();
        total++;
        if (fifo_rd_en !== 1'b0) begin
            bad++; $display("FAIL reset_rd_en got=%0b want=0", fifo_rd_en);
        end
        total++;
        if ({m_valid, m_sop, m_eop, m_err} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {m_valid, m_sop, m_eop, m_err});
        end
        total++;
        if ({m_data, m_len} !== 24'h0) begin
            bad++; $display("FAIL reset_data_len got=%h want=000000", {m_data, m_len});
        end
        total++;
        if ({frame_cnt, err_cnt, trunc_cnt} !== 96'h0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", frame_cnt, err_cnt, trunc_cnt);
        end
        $display("reset checked");
    endtask

    task automatic test_single_byte();
        rd_rst_n = 1'b1;
        #1;
        total++;
        if (fifo_rd_en !== 1'b1) begin
            bad++; $display("FAIL single_rd_en_c0 got=%0b want=1", fifo_rd_en);
        end
        tick();
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL single_valid_c1 got=%0b want=0", m_valid);
        end
        tick();
        total++;
        if ({m_valid, m_sop, m_eop, m_err, m_data, m_len} !== {4'b1110, 8'h5A, 16'd1}) begin
            bad++; $display("FAIL single_beat_c2 got=%b/%h/%0d want=1110/5a/1",
                            {m_valid, m_sop, m_eop, m_err}, m_data, m_len);
        end
        tick();
        total++;
        if (frame_cnt !== 32'd1) begin
            bad++; $display("FAIL single_frame_cnt got=%0d want=1", frame_cnt);
        end
        $display("frame single beats=1 len=1");
    endtask

    task automatic test_frame64();
        int s;
        bit ok;
        s = cap_n;
        push_frame(64, 8'h00, 1'b1, 1'b1);
        wait_beats(s + 64, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL f64_timeout got=%0d want=%0d", cap_n - s, 64);
        end
        for (int i = 0; i < 64; i++) begin
            total++;
            if ({cap_data[s+i], cap_sop[s+i], cap_eop[s+i]} !== {8'(i), i == 0, i == 63}) begin
                bad++; $display("FAIL f64_beat%0d got=%h/%b%b want=%h/%b%b", i, cap_data[s+i],
                                cap_sop[s+i], cap_eop[s+i], 8'(i), i == 0, i == 63);
            end
        end
        total++;
        if ({cap_err[s+63], cap_len[s+63]} !== {1'b1, 16'd64}) begin
            bad++; $display("FAIL f64_eop got=err%0b len%0d want=err1 len64", cap_err[s+63], cap_len[s+63]);
        end
        total++;
        if (cap_cyc[s+63] - cap_cyc[s] !== 63) begin
            bad++; $display("FAIL f64_throughput got=%0d want=63", cap_cyc[s+63] - cap_cyc[s]);
        end
        tick();
        total++;
        if ({frame_cnt, err_cnt, trunc_cnt} !== {32'd2, 32'd1, 32'd0}) begin
            bad++; $display("FAIL f64_counters got=%0d/%0d/%0d want=2/1/0", frame_cnt, err_cnt, trunc_cnt);
        end
        $display("frame f64 beats=64 len=%0d", cap_len[s+63]);
    endtask

    task automatic test_truncate();
        int s;
        int s2;
        bit ok;
        s = cap_n;
        push_frame(1600, 8'h00, 1'b0, 1'b1);
        push_frame(10, 8'h80, 1'b0, 1'b1);
        wait_beats(s + 1546, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL trunc_timeout got=%0d want=1546", cap_n - s);
        end
        for (int i = 0; i < 1536; i++) begin
            total++;
            if ({cap_data[s+i], cap_sop[s+i], cap_eop[s+i]} !== {8'(i), i == 0, i == 1535}) begin
                bad++; $display("FAIL trunc_beat%0d got=%h/%b%b want=%h/%b%b", i, cap_data[s+i],
                                cap_sop[s+i], cap_eop[s+i], 8'(i), i == 0, i == 1535);
            end
        end
        total++;
        if ({cap_err[s+1535], cap_len[s+1535]} !== {1'b1, 16'd1536}) begin
            bad++; $display("FAIL trunc_eop got=err%0b len%0d want=err1 len1536", cap_err[s+1535], cap_len[s+1535]);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({cap_data[s+1536+i], cap_sop[s+1536+i], cap_eop[s+1536+i]} !== {8'h80 + 8'(i), i == 0, i == 9}) begin
                bad++; $display("FAIL trunc_next_beat%0d got=%h/%b%b want=%h/%b%b", i, cap_data[s+1536+i],
                                cap_sop[s+1536+i], cap_eop[s+1536+i], 8'h80 + 8'(i), i == 0, i == 9);
            end
        end
        total++;
        if ({cap_err[s+1545], cap_len[s+1545]} !== {1'b0, 16'd10}) begin
            bad++; $display("FAIL trunc_next_eop got=err%0b len%0d want=err0 len10", cap_err[s+1545], cap_len[s+1545]);
        end
        $display("frame trunc beats=1536 len=%0d then beats=10 len=%0d", cap_len[s+1535], cap_len[s+1545]);
        // Exactly c_MAX_LEN bytes ending on its own eop is a normal frame
        s2 = cap_n;
        push_frame(1536, 8'h11, 1'b0, 1'b1);
        wait_beats(s2 + 1536, ok);
        repeat (4) tick();
        total++;
        if (cap_n - s2 !== 1536) begin
            bad++; $display("FAIL exact_beats got=%0d want=1536", cap_n - s2);
        end
        total++;
        if ({cap_sop[s2], cap_data[s2], cap_eop[s2+1535], cap_err[s2+1535], cap_len[s2+1535]} !==
            {1'b1, 8'h11, 1'b1, 1'b0, 16'd1536}) begin
            bad++; $display("FAIL exact_frame got=sop%0b %h eop%0b err%0b len%0d want=sop1 11 eop1 err0 len1536",
                            cap_sop[s2], cap_data[s2], cap_eop[s2+1535], cap_err[s2+1535], cap_len[s2+1535]);
        end
        total++;
        if ({frame_cnt, err_cnt, trunc_cnt} !== {32'd5, 32'd2, 32'd1}) begin
            bad++; $display("FAIL trunc_counters got=%0d/%0d/%0d want=5/2/1", frame_cnt, err_cnt, trunc_cnt);
        end
        $display("frame exact beats=%0d len=%0d", cap_n - s2, cap_len[s2+1535]);
    endtask

    task automatic test_backpressure();
        int s;
        bit ok;
        s = cap_n;
        occ_base  = issued_n - accepted_n;
        chk_occ   = 1'b1;
        toggle_en = 1'b1;
        push_frame(20, 8'h40, 1'b0, 1'b1);
        wait_beats(s + 20, ok);
        toggle_en = 1'b0;
        repeat (3) tick();
        chk_occ = 1'b0;
        total++;
        if (cap_n - s !== 20) begin
            bad++; $display("FAIL bp_beats got=%0d want=20", cap_n - s);
        end
        for (int i = 0; i < 20; i++) begin
            total++;
            if ({cap_data[s+i], cap_sop[s+i], cap_eop[s+i]} !== {8'h40 + 8'(i), i == 0, i == 19}) begin
                bad++; $display("FAIL bp_beat%0d got=%h/%b%b want=%h/%b%b", i, cap_data[s+i],
                                cap_sop[s+i], cap_eop[s+i], 8'h40 + 8'(i), i == 0, i == 19);
            end
        end
        total++;
        if (cap_len[s+19] !== 16'd20) begin
            bad++; $display("FAIL bp_len got=%0d want=20", cap_len[s+19]);
        end
        total++;
        if (stab_bad !== 0) begin
            bad++; $display("FAIL bp_stable got=%0d want=0 changes while stalled", stab_bad);
        end
        total++;
        if (occ_bad !== 0) begin
            bad++; $display("FAIL bp_rd_en_full got=%0d want=0 reads with buffer full", occ_bad);
        end
        total++;
        if (frame_cnt !== 32'd6) begin
            bad++; $display("FAIL bp_frame_cnt got=%0d want=6", frame_cnt);
        end
        $display("frame bp beats=%0d len=%0d", cap_n - s, cap_len[s+19]);
    endtask

    task automatic test_empty_gap();
        int s;
        bit ok;
        s = cap_n;
        push_frame(30, 8'hC0, 1'b0, 1'b1);
        wait_beats(s + 8, ok);
        gap = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (fifo_rd_en !== 1'b0) begin
                bad++; $display("FAIL gap_rd_en_c%0d got=%0b want=0", i, fifo_rd_en);
            end
            tick();
        end
        gap = 1'b0;
        wait_beats(s + 30, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL gap_timeout got=%0d want=30", cap_n - s);
        end
        for (int i = 0; i < 30; i++) begin
            total++;
            if ({cap_data[s+i], cap_sop[s+i], cap_eop[s+i]} !== {8'hC0 + 8'(i), i == 0, i == 29}) begin
                bad++; $display("FAIL gap_beat%0d got=%h/%b%b want=%h/%b%b", i, cap_data[s+i],
                                cap_sop[s+i], cap_eop[s+i], 8'hC0 + 8'(i), i == 0, i == 29);
            end
        end
        total++;
        if ({cap_err[s+29], cap_len[s+29]} !== {1'b0, 16'd30}) begin
            bad++; $display("FAIL gap_eop got=err%0b len%0d want=err0 len30", cap_err[s+29], cap_len[s+29]);
        end
        total++;
        if (cap_cyc[s+29] - cap_cyc[s] <= 29) begin
            bad++; $display("FAIL gap_valid_hole got=%0d want>29", cap_cyc[s+29] - cap_cyc[s]);
        end
        total++;
        if (empty_bad !== 0) begin
            bad++; $display("FAIL rd_en_while_empty got=%0d want=0", empty_bad);
        end
        $display("frame gap beats=30 len=%0d", cap_len[s+29]);
    endtask

    task automatic test_reset_midframe();
        int s;
        bit ok;
        s = cap_n;
        push_frame(5, 8'h30, 1'b0, 1'b0);
        wait_beats(s + 5, ok);
        tick();
        rd_rst_n = 1'b0;
        tick();
        total++;
        if ({m_valid, m_sop, m_eop, m_err, m_data, m_len} !== 28'h0) begin
            bad++; $display("FAIL midrst_outputs got=%h want=0", {m_valid, m_sop, m_eop, m_err, m_data, m_len});
        end
        total++;
        if ({frame_cnt, err_cnt, trunc_cnt} !== 96'h0) begin
            bad++; $display("FAIL midrst_counters got=%0d/%0d/%0d want=0/0/0", frame_cnt, err_cnt, trunc_cnt);
        end
        rd_rst_n = 1'b1;
        s = cap_n;
        push_frame(3, 8'hA0, 1'b0, 1'b1);
        wait_beats(s + 3, ok);
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({cap_data[s+i], cap_sop[s+i], cap_eop[s+i]} !== {8'hA0 + 8'(i), i == 0, i == 2}) begin
                bad++; $display("FAIL midrst_beat%0d got=%h/%b%b want=%h/%b%b", i, cap_data[s+i],
                                cap_sop[s+i], cap_eop[s+i], 8'hA0 + 8'(i), i == 0, i == 2);
            end
        end
        total++;
        if (cap_len[s+2] !== 16'd3) begin
            bad++; $display("FAIL midrst_len got=%0d want=3", cap_len[s+2]);
        end
        total++;
        if ({frame_cnt, err_cnt, trunc_cnt} !== {32'd1, 32'd0, 32'd0}) begin
            bad++; $display("FAIL midrst_counters_after got=%0d/%0d/%0d want=1/0/0", frame_cnt, err_cnt, trunc_cnt);
        end
        $display("frame after_reset beats=%0d len=%0d", cap_n - s, cap_len[s+2]);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_frame64();
        test_truncate();
        test_backpressure();
        test_empty_gap();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tsmac_rx_fifo_reader.md
Name: tsmac_rx_fifo_reader

Overview:
- Read-side consumer of the TSMAC RX clock-crossing FIFO, in the rd_clk domain.
- Pops 10-bit FIFO words and delineates frames, presenting them on a valid/ready byte stream with sop/eop/err markers and frame length.
- Enforces a maximum frame length by truncating oversize frames and discarding their remainder.
- Keeps frame, error and truncation statistics counters.

Parameters:
c_DATA_WIDTH, 8, payload byte width; FIFO word width is c_DATA_WIDTH+2
c_MAX_LEN, 1536, maximum emitted frame length in bytes (legal 64..65535)
c_LEN_WIDTH, 16, width of the length counter and m_len
c_CNT_WIDTH, 32, width of the statistics counters

Ports:
rd_clk  in  1  single clock, the FIFO read clock
rd_rst_n  in  1  synchronous active-low reset
fifo_rd_data  in  c_DATA_WIDTH+2  FIFO word: [DW+1]=eop, [DW]=err (meaningful with eop), [DW-1:0]=byte
fifo_rd_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read enable; data is returned on fifo_rd_data one cycle later
m_valid  out  1  output beat valid
m_ready  in  1  downstream accept
m_data  out  c_DATA_WIDTH  output byte
m_sop  out  1  first byte of frame
m_eop  out  1  last byte of frame
m_err  out  1  frame error, valid with m_eop
m_len  out  c_LEN_WIDTH  frame byte count, valid with m_eop
frame_cnt  out  c_CNT_WIDTH  frames emitted (eop beats accepted)
err_cnt  out  c_CNT_WIDTH  frames emitted with m_err=1
trunc_cnt  out  c_CNT_WIDTH  frames truncated

Behaviour:
- Reset (rd_rst_n=0 at a rd_clk edge): all outputs are 0; buffer empty; rd_pend=0; state=IDLE; len=0; counters=0.
  - A FIFO word returning in the cycle after reset is ignored.
  - rd_rst_n is asserted together with the FIFO rd_rst.
- Read issue: fifo_rd_en = ~fifo_rd_empty & (buf_cnt + rd_pend - fire < 2).
  - rd_pend is the registered fifo_rd_en.
  - fire = m_valid & m_ready.
  - fifo_rd_en is never asserted while fifo_rd_empty=1.
- Output buffer: 2-entry FIFO of {data, sop, eop, err, len}.
  - m_valid = (buf_cnt != 0); outputs show the head entry.
  - Fire and write in the same cycle leave buf_cnt unchanged.
  - Overflow is impossible by the issue rule.
  - Sustained throughput is 1 byte/cycle when m_ready=1.
  - Latency from fifo_rd_en to m_valid is 2 cycles.
- Returned word processing (when rd_pend=1), by state:
  - IDLE: word is written with sop=1 and len:=1.
    - If eop: write eop=1, err=word err, len=1; stay in IDLE.
    - Else: go to FRAME.
  - FRAME: len:=len+1.
    - If eop: write eop=1, err=word err, m_len=len+1; go to IDLE.
    - Else if len+1 == c_MAX_LEN: write eop=1, err=1, m_len=c_MAX_LEN; go to DROP.
    - Else: write a plain byte.
  - DROP: the word is not written to the buffer.
    - If eop: go to IDLE.
    - Else: stay in DROP.
  - c_MAX_LEN=1 behaviour is not required.
- Truncation takes priority only when the word is not eop; a frame of exactly c_MAX_LEN bytes ending on its own eop is emitted normally.
- Counters update on fire of an eop beat:
  - frame_cnt+1.
  - err_cnt+1 if err.
  - trunc_cnt+1 if truncated (a per-entry flag is held in the buffer).
  - Counters wrap at 2^c_CNT_WIDTH.
- Backpressure: m_ready=0 holds the head entry and all m_* outputs stable; reads stall once buf_cnt + rd_pend = 2.
- FIFO running empty mid-frame inserts m_valid gaps only; frame state is preserved.

Test Plan:
1. Reset release, FIFO holds 1-byte frame {eop=1,err=0,0x5A}, m_ready=1 -> fifo_rd_en at cycle 0; m_valid at cycle 2 with m_sop=1, m_eop=1, m_data=0x5A, m_len=1; frame_cnt=1.
2. 64-byte frame, bytes 0x00..0x3F, last word err=1, m_ready=1 -> 64 consecutive beats; sop on 0x00; eop on 0x3F with err=1, len=64; err_cnt=1.
3. 1600-byte frame with c_MAX_LEN=1536, then a 10-byte good frame -> 1536 beats, last with eop=1, err=1, len=1536; 64 words discarded; next frame starts with sop, len=10; trunc_cnt=1, frame_cnt=2.
4. m_ready toggling 1/0 every cycle on a 20-byte frame -> no lost or duplicated bytes; outputs stable while m_ready=0; fifo_rd_en never raised with buf_cnt + rd_pend = 2.
5. fifo_rd_empty asserted for 5 cycles mid-frame -> fifo_rd_en=0 during the gap; m_valid gaps only; len continues correctly, e.g. 30-byte frame reports len=30.
6. rd_rst_n pulled low for 1 cycle mid-frame -> all outputs 0, counters 0; the next FIFO word is treated as sop.
